// File: rtl/sm_mult_pkg.sv
// sm_mult_pkg: shared types and helpers for the sequential sign-magnitude multiplier.
// Optional feature macro used by sm_mult_seq: SM_MULT_SEQ_EARLY_TERM_EN.
package sm_mult_pkg;

   localparam int DEF_MAG_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sign bit of a {sign, magnitude} operand whose magnitude is mag_w bits wide.
   function automatic logic sign_of(input logic [31:0] x, input int mag_w);
      return x[mag_w];
   endfunction

   // Magnitude field of a {sign, magnitude} operand, zero-extended to 32 bits.
   function automatic logic [31:0] mag_of(input logic [31:0] x, input int mag_w);
      return x & ((32'd1 << mag_w) - 32'd1);
   endfunction

endpackage

// File: rtl/sm_mult_step.sv
// sm_mult_step: one shift-add partial-product step, acc + (bit ? mag_a << k : 0).
// Purely combinational so the controller FSM and the datapath stay separable.
module sm_mult_step
   import sm_mult_pkg::*;
#(
   parameter int MAG_W = DEF_MAG_W,
   parameter int CNT_W = 1
) (
   input  logic [2*MAG_W-1:0] i_acc,
   input  logic [MAG_W-1:0]   i_mag_a,
   input  logic               i_bit,
   input  logic [CNT_W-1:0]   i_k,
   output logic [2*MAG_W-1:0] o_acc_next
);

   logic [2*MAG_W-1:0] w_pp;

   // Partial product is the multiplicand aligned to the weight of multiplier bit k.
   assign w_pp       = i_bit ? ({{MAG_W{1'b0}}, i_mag_a} << i_k) : '0;
   assign o_acc_next = i_acc + w_pp;

endmodule

// File: rtl/sm_mult_seq.sv
// sm_mult_seq: sequential shift-add sign-magnitude multiplier, one multiplier bit per clock.
// Optional feature macro: SM_MULT_SEQ_EARLY_TERM_EN (stop as soon as the remaining
// multiplier bits are zero, and skip RUN entirely for zero-magnitude operands).
module sm_mult_seq
   import sm_mult_pkg::*;
#(
   parameter  int MAG_W  = DEF_MAG_W,
   localparam int PROD_W = 2*MAG_W+1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MAG_W:0]    a,
   input  logic [MAG_W:0]    b,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product,
   output logic              zeroFlag
);

   localparam int ACC_W = 2*MAG_W;
   // Counter only ever holds 0..MAG_W-1, so it is exactly an index into the multiplier.
   localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

   state_t             r_state, w_state_next;
   logic [MAG_W-1:0]   r_mag_a, r_mag_b;
   logic               r_sign;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic [PROD_W-1:0]  r_product;
   logic               r_zero;

   logic [MAG_W-1:0]   w_mag_a_in, w_mag_b_in;
   logic               w_sign_in;
   logic [ACC_W-1:0]   w_acc_next;
   logic               w_accept;
   logic               w_last;
   logic               w_run_exit;
   logic               w_skip;
   logic               w_zero_run;

   assign w_mag_a_in = MAG_W'(mag_of(32'(a), MAG_W));
   assign w_mag_b_in = MAG_W'(mag_of(32'(b), MAG_W));
   assign w_sign_in  = sign_of(32'(a), MAG_W) ^ sign_of(32'(b), MAG_W);

   assign w_accept   = start & ready;
   assign w_last     = (r_count == CNT_W'(MAG_W-1));
   assign w_zero_run = (r_mag_a == '0) | (r_mag_b == '0);

`ifdef SM_MULT_SEQ_EARLY_TERM_EN
   logic w_zero_in;
   assign w_zero_in  = (w_mag_a_in == '0) | (w_mag_b_in == '0);
   // Leave RUN once no set multiplier bit remains above the current one.
   assign w_run_exit = w_last | (((r_mag_b >> r_count) >> 1) == '0);
   assign w_skip     = w_zero_in;
`else
   assign w_run_exit = w_last;
   assign w_skip     = 1'b0;
`endif

   sm_mult_step #(
      .MAG_W (MAG_W),
      .CNT_W (CNT_W)
   ) u_step (
      .i_acc      (r_acc),
      .i_mag_a    (r_mag_a),
      .i_bit      (r_mag_b[r_count]),
      .i_k        (r_count),
      .o_acc_next (w_acc_next)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and handshake outputs; DONE accepts a new start like IDLE does.
   always_comb begin
      w_state_next = r_state;
      ready        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) w_state_next = w_skip ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_run_exit) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) w_state_next = w_skip ? ST_DONE : ST_RUN;
            else       w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand capture, accumulation, and result registers (updated on DONE entry only).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_sign    <= 1'b0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
         r_zero    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mag_a <= w_mag_a_in;
            r_mag_b <= w_mag_b_in;
            r_sign  <= w_sign_in;
            r_acc   <= '0;
            r_count <= '0;
         end else if (r_state == ST_RUN) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CNT_W'(1);
         end

         if ((r_state == ST_RUN) && w_run_exit) begin
            // Zero results are forced to +0 so -0 never leaves the block.
            r_product <= {r_sign & ~w_zero_run, w_acc_next};
            r_zero    <= w_zero_run;
         end
`ifdef SM_MULT_SEQ_EARLY_TERM_EN
         else if (w_accept && w_skip) begin
            r_product <= '0;
            r_zero    <= 1'b1;
         end
`endif
      end
   end

   assign product  = r_product;
   assign zeroFlag = r_zero;

endmodule

// File: tb/tb_sm_mult_seq.sv
// tb_sm_mult_seq: directed literal cases plus randomized traffic against a
// cycle-count behavioural model of the sign-magnitude multiplier.
module tb_sm_mult_seq;

   localparam int MAG_W  = 2;
   localparam int OP_W   = MAG_W + 1;
   localparam int PROD_W = 2*MAG_W + 1;

`ifdef SM_MULT_SEQ_EARLY_TERM_EN
   localparam int LAT_ZERO  = 1;
   localparam int LAT_EARLY = 2;
`else
   localparam int LAT_ZERO  = 3;
   localparam int LAT_EARLY = 3;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [OP_W-1:0]   a = '0;
   logic [OP_W-1:0]   b = '0;
   logic              ready, busy, done, zeroFlag;
   logic [PROD_W-1:0] product;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Model: cycles of RUN still to go, plus the result the next done must show.
   int                m_cnt  = 0;
   bit                m_done = 1'b0;
   logic [PROD_W-1:0] m_prod = '0;
   bit                m_zero = 1'b0;
   logic [PROD_W-1:0] p_prod = '0;
   bit                p_zero = 1'b0;

   sm_mult_seq #(.MAG_W(MAG_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .zeroFlag (zeroFlag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PROD_W-1:0] ref_prod(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
      int mx, my, p;
      bit s;
      mx = int'(x[MAG_W-1:0]);
      my = int'(y[MAG_W-1:0]);
      p  = mx * my;
      s  = (x[MAG_W] ^ y[MAG_W]) && (p != 0);
      return {s, (2*MAG_W)'(p)};
   endfunction

   function automatic bit ref_zero(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
      return (x[MAG_W-1:0] == '0) || (y[MAG_W-1:0] == '0);
   endfunction

   // Cycles from the accepting edge to the cycle where done is high.
   function automatic int lat_of(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
`ifdef SM_MULT_SEQ_EARLY_TERM_EN
      int my, hb;
      if (ref_zero(x, y)) return 1;
      my = int'(y[MAG_W-1:0]);
      hb = 0;
      for (int i = 0; i < MAG_W; i++) if (((my >> i) & 1) != 0) hb = i;
      return hb + 2;
`else
      return MAG_W + 1;
`endif
   endfunction

   // Behavioural model, advanced on every rising edge.
   always @(posedge clk) begin : model
      int lat;
      if (!rst_n) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_prod <= '0;
         m_zero <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt  <= m_cnt - 1;
         m_done <= (m_cnt == 1);
         if (m_cnt == 1) begin
            m_prod <= p_prod;
            m_zero <= p_zero;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            lat    = lat_of(a, b);
            p_prod <= ref_prod(a, b);
            p_zero <= ref_zero(a, b);
            if (lat == 1) begin
               m_done <= 1'b1;
               m_prod <= ref_prod(a, b);
               m_zero <= ref_zero(a, b);
            end else begin
               m_cnt <= lat - 1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready",    32'(ready),    32'(m_cnt == 0));
         chk("busy",     32'(busy),     32'(m_cnt > 0));
         chk("done",     32'(done),     32'(m_done));
         chk("product",  32'(product),  32'(m_prod));
         chk("zeroFlag", 32'(zeroFlag), 32'(m_zero));
      end
   end

   // Issue one operation from the current (negedge) point and check its literal result.
   task automatic op(input logic [OP_W-1:0] ta, input logic [OP_W-1:0] tb,
                     input bit pulse, input logic [PROD_W-1:0] ep, input bit ez,
                     input int el, input string nm);
      int n;
      bit seen;
      a = ta; b = tb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = OP_W'($urandom);
      b = OP_W'($urandom);
      n = 0; seen = 1'b0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (pulse && n == 1) begin
            start = 1'b1; a = OP_W'($urandom); b = OP_W'($urandom);
         end else if (pulse && n == 2) begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
      end
      chk($sformatf("%s_lat", nm),  32'(n),        32'(el));
      chk($sformatf("%s_prod", nm), 32'(product),  32'(ep));
      chk($sformatf("%s_zero", nm), 32'(zeroFlag), 32'(ez));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready",   32'(ready),    32'd1);
      chk("rst_busy",    32'(busy),     32'd0);
      chk("rst_done",    32'(done),     32'd0);
      chk("rst_product", 32'(product),  32'd0);
      chk("rst_zero",    32'(zeroFlag), 32'd0);
      rst_n = 1'b1;
      idle(1);

      op(3'b011, 3'b110, 1'b0, 5'b10110, 1'b0, 3, "sign_mix");
      idle(2);
      op(3'b011, 3'b111, 1'b0, 5'b11001, 1'b0, 3, "max_neg");
      op(3'b111, 3'b111, 1'b0, 5'b01001, 1'b0, 3, "max_pos_b2b");
      idle(2);
      op(3'b100, 3'b011, 1'b0, 5'b00000, 1'b1, LAT_ZERO, "zero");
      idle(2);
      op(3'b011, 3'b110, 1'b1, 5'b10110, 1'b0, 3, "busy_ign");
      idle(1);
      chk("busy_ign_single_done", 32'(done), 32'd0);
      idle(1);
      op(3'b010, 3'b001, 1'b0, 5'b00010, 1'b0, LAT_EARLY, "early");
      idle(2);

      // Reset in the middle of RUN.
      a = 3'b011; b = 3'b011; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready",   32'(ready),   32'd1);
      chk("midrst_busy",    32'(busy),    32'd0);
      chk("midrst_done",    32'(done),    32'd0);
      chk("midrst_product", 32'(product), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_done", 32'(done), 32'd0);
      end
      op(3'b011, 3'b011, 1'b0, 5'b01001, 1'b0, 3, "after_rst");
      idle(2);

      // Randomized traffic, including back-to-back starts and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 2) != 0);
         a     = OP_W'($urandom);
         b     = OP_W'($urandom);
         rst_n = ($urandom_range(0, 99) != 0);
         @(negedge clk);
      end
      start = 1'b0;
      rst_n = 1'b1;
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
